// File: rtl/addroundkey_stage.sv
// AES AddRoundKey stage: XORs each incoming state block with the next round key
// taken from a small key FIFO, parking one block when no key is available.
module addroundkey_stage #(
    parameter int WORD   = 32,
    parameter int NB     = 4,
    parameter int KDEPTH = 4,
    parameter int NR     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [WORD*NB-1:0]   i_block,
    input  logic                 k_valid,
    output logic                 k_ready,
    input  logic [WORD*NB-1:0]   k_roundkey,
    output logic                 o_valid,
    output logic [WORD*NB-1:0]   o_block,
    output logic [3:0]           o_round,
    output logic                 o_overflow
);

    localparam int BW = WORD * NB;
    localparam int PW = $clog2(KDEPTH);
    localparam int CW = PW + 1;

    logic [BW-1:0] key_mem [KDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          hold_full;
    logic [BW-1:0] hold_block;
    logic          round_seen;

    logic          push;
    logic          pop;
    logic          keys_avail;
    logic [BW-1:0] src_block;
    logic [3:0]    round_next;

    assign k_ready    = !rst && (count != CW'(KDEPTH));
    assign keys_avail = (count != '0);
    assign push       = k_valid && k_ready;
    assign pop        = keys_avail && (hold_full || i_valid);
    assign src_block  = hold_full ? hold_block : i_block;

    // NOTE: every variable driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        round_next = 4'd0;
        if (round_seen && (o_round != 4'(NR)))
            round_next = o_round + 4'd1;
    end

    // NOTE: key storage has no reset; entries are only read once count says
    // they were written, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (push)
            key_mem[wr_ptr] <= k_roundkey;
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Hold register: an older parked block always wins over a new arrival.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full  <= 1'b0;
            hold_block <= '0;
            o_overflow <= 1'b0;
        end else if (hold_full) begin
            if (keys_avail) begin
                hold_full <= i_valid;
                if (i_valid)
                    hold_block <= i_block;
            end else if (i_valid) begin
                o_overflow <= 1'b1;
            end
        end else if (i_valid && !keys_avail) begin
            hold_full  <= 1'b1;
            hold_block <= i_block;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_block    <= '0;
            o_round    <= 4'd0;
            round_seen <= 1'b0;
        end else begin
            o_valid <= pop;
            if (pop) begin
                o_block    <= src_block ^ key_mem[rd_ptr];
                o_round    <= round_next;
                round_seen <= 1'b1;
            end
        end
    end

endmodule
